// File: rtl/seven_seg_bcd_counter.sv
// ---------------------------------------------------------------------------
// seven_seg_bcd_counter
//
// Two-digit BCD event counter (00..99, wrapping) driving both seven-segment
// digits of the Go Board. On every wrap the display runs a flash sequence:
// dark, shown, dark, shown, each phase CLKS_PER_BLINK cycles long.
//
// Ports
//   i_clk                 system clock, everything on the rising edge
//   i_rst                 synchronous active-high reset
//   i_inc / i_dec         count pulses, one step per high cycle
//   i_clr                 clear count to 00 and abort any flash
//   i_blank_lz            blank the tens digit while it is 0
//   o_tens / o_ones       registered BCD digits
//   o_wrap                one-cycle pulse on 99->00 or 00->99
//   o_seg1a..o_seg1g      tens digit segments, active-low, registered
//   o_seg2a..o_seg2g      ones digit segments, active-low, registered
// ---------------------------------------------------------------------------
module seven_seg_bcd_counter #(
    parameter int CLKS_PER_BLINK = 12_500_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_inc,
    input  logic       i_dec,
    input  logic       i_clr,
    input  logic       i_blank_lz,
    output logic [3:0] o_tens,
    output logic [3:0] o_ones,
    output logic       o_wrap,
    output logic       o_seg1a,
    output logic       o_seg1b,
    output logic       o_seg1c,
    output logic       o_seg1d,
    output logic       o_seg1e,
    output logic       o_seg1f,
    output logic       o_seg1g,
    output logic       o_seg2a,
    output logic       o_seg2b,
    output logic       o_seg2c,
    output logic       o_seg2d,
    output logic       o_seg2e,
    output logic       o_seg2f,
    output logic       o_seg2g
);

    localparam logic [23:0] TIMER_LAST = 24'(CLKS_PER_BLINK - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OFF1,
        ST_ON1,
        ST_OFF2,
        ST_ON2
    } flash_state_e;

    // -----------------------------------------------------------------------
    // BCD counter
    // -----------------------------------------------------------------------
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       wrap_q, wrap_d;

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        wrap_d = 1'b0;
        if (i_clr) begin
            tens_d = 4'd0;
            ones_d = 4'd0;
        end else if (i_inc && !i_dec) begin
            if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                if (tens_q == 4'd9) begin
                    tens_d = 4'd0;
                    wrap_d = 1'b1;
                end else begin
                    tens_d = tens_q + 4'd1;
                end
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end else if (i_dec && !i_inc) begin
            if (ones_q == 4'd0) begin
                ones_d = 4'd9;
                if (tens_q == 4'd0) begin
                    tens_d = 4'd9;
                    wrap_d = 1'b1;
                end else begin
                    tens_d = tens_q - 4'd1;
                end
            end else begin
                ones_d = ones_q - 4'd1;
            end
        end
        // i_inc and i_dec together fall through: count holds
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tens_q <= 4'd0;
            ones_q <= 4'd0;
            wrap_q <= 1'b0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
            wrap_q <= wrap_d;
        end
    end

    assign o_tens = tens_q;
    assign o_ones = ones_q;
    assign o_wrap = wrap_q;

    // -----------------------------------------------------------------------
    // Flash sequencer. The wrap is taken from the next-state value so the
    // FSM enters OFF1 on the same edge that raises o_wrap.
    // -----------------------------------------------------------------------
    flash_state_e state_q, state_d;
    logic [23:0]  timer_q, timer_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            timer_q <= 24'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (i_clr) begin
            state_d = ST_IDLE;
            timer_d = 24'd0;
        end else if (wrap_d) begin
            state_d = ST_OFF1;
            timer_d = 24'd0;
        end else if (state_q != ST_IDLE) begin
            if (timer_q == TIMER_LAST) begin
                timer_d = 24'd0;
                case (state_q)
                    ST_OFF1: state_d = ST_ON1;
                    ST_ON1:  state_d = ST_OFF2;
                    ST_OFF2: state_d = ST_ON2;
                    default: state_d = ST_IDLE;
                endcase
            end else begin
                timer_d = timer_q + 24'd1;
            end
        end
    end

    logic flash_dark;
    assign flash_dark = (state_q == ST_OFF1) || (state_q == ST_OFF2);

    // -----------------------------------------------------------------------
    // Segment output registers, one per digit (index 0 = tens, 1 = ones)
    // -----------------------------------------------------------------------
    // Returns the lit-segment mask {a,b,c,d,e,f,g}, 1 = lit.
    function automatic logic [6:0] seg_lit(input logic [3:0] d);
        logic [6:0] m;
        case (d)
            4'd0:    m = 7'b1111110;
            4'd1:    m = 7'b0110000;
            4'd2:    m = 7'b1101101;
            4'd3:    m = 7'b1111001;
            4'd4:    m = 7'b0110011;
            4'd5:    m = 7'b1011011;
            4'd6:    m = 7'b1011111;
            4'd7:    m = 7'b1110000;
            4'd8:    m = 7'b1111111;
            4'd9:    m = 7'b1111011;
            default: m = 7'b0000000;
        endcase
        return m;
    endfunction

    logic [3:0] digit_val   [2];
    logic       digit_blank [2];
    logic [6:0] seg_bus     [2];

    assign digit_val[0]   = tens_q;
    assign digit_val[1]   = ones_q;
    // Leading-zero blanking only ever applies to the tens digit.
    assign digit_blank[0] = flash_dark || (i_blank_lz && (tens_q == 4'd0));
    assign digit_blank[1] = flash_dark;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_digit
            logic [6:0] seg_q;
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    seg_q <= 7'h7F;
                end else if (digit_blank[gi]) begin
                    seg_q <= 7'h7F;
                end else begin
                    seg_q <= ~seg_lit(digit_val[gi]);
                end
            end
            assign seg_bus[gi] = seg_q;
        end
    endgenerate

    assign {o_seg1a, o_seg1b, o_seg1c, o_seg1d, o_seg1e, o_seg1f, o_seg1g} = seg_bus[0];
    assign {o_seg2a, o_seg2b, o_seg2c, o_seg2d, o_seg2e, o_seg2f, o_seg2g} = seg_bus[1];

endmodule

// File: tb/tb_seven_seg_bcd_counter.sv
// ---------------------------------------------------------------------------
// Testbench for seven_seg_bcd_counter (CLKS_PER_BLINK = 4).
// Reference model: count as an integer 0..99 with modular arithmetic, flash
// as the age (in cycles) since the last wrap, segments from a table of
// lit-segment letter strings.
// ---------------------------------------------------------------------------
module tb_seven_seg_bcd_counter;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       inc = 1'b0;
    logic       dec = 1'b0;
    logic       clr = 1'b0;
    logic       blz = 1'b0;
    logic [3:0] o_tens, o_ones;
    logic       o_wrap;
    logic       s1a, s1b, s1c, s1d, s1e, s1f, s1g;
    logic       s2a, s2b, s2c, s2d, s2e, s2f, s2g;
    logic [6:0] seg1, seg2;

    assign seg1 = {s1a, s1b, s1c, s1d, s1e, s1f, s1g};
    assign seg2 = {s2a, s2b, s2c, s2d, s2e, s2f, s2g};

    seven_seg_bcd_counter #(.CLKS_PER_BLINK(C)) dut (
        .i_clk(clk), .i_rst(rst), .i_inc(inc), .i_dec(dec), .i_clr(clr),
        .i_blank_lz(blz), .o_tens(o_tens), .o_ones(o_ones), .o_wrap(o_wrap),
        .o_seg1a(s1a), .o_seg1b(s1b), .o_seg1c(s1c), .o_seg1d(s1d),
        .o_seg1e(s1e), .o_seg1f(s1f), .o_seg1g(s1g),
        .o_seg2a(s2a), .o_seg2b(s2b), .o_seg2c(s2c), .o_seg2d(s2d),
        .o_seg2e(s2e), .o_seg2f(s2f), .o_seg2g(s2g)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int nstep = 0;

    // model state
    int         cnt = 0;
    int         age = -1;     // -1 = no flash, else cycles since the wrap edge
    logic       exp_wrap = 1'b0;
    logic [6:0] exp_seg1 = 7'h7F;
    logic [6:0] exp_seg2 = 7'h7F;

    string lit_tbl [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                            "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    // Active-low pattern {a..g} built from the letters of lit segments.
    function automatic logic [6:0] seg_of(input int d);
        string      s;
        logic [6:0] m;
        int         idx;
        s = lit_tbl[d];
        m = 7'h7F;
        for (int i = 0; i < s.len(); i++) begin
            idx = 6 - (int'(s[i]) - 97);
            m[idx] = 1'b0;
        end
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (step %0d)", tag, obs, exp, nstep);
        end
    endtask

    // Apply current inputs at the next rising edge, advance the model, check.
    task automatic step();
        logic dark;
        if (rst) begin
            exp_seg1 = 7'h7F;
            exp_seg2 = 7'h7F;
        end else begin
            dark = (age >= 0) && (((age / C) % 2) == 0);
            exp_seg1 = (dark || (blz && (cnt / 10 == 0))) ? 7'h7F : seg_of(cnt / 10);
            exp_seg2 = dark ? 7'h7F : seg_of(cnt % 10);
        end
        exp_wrap = 1'b0;
        if (rst || clr) begin
            cnt = 0;
        end else if (inc && !dec) begin
            exp_wrap = (cnt == 99);
            cnt = (cnt + 1) % 100;
        end else if (dec && !inc) begin
            exp_wrap = (cnt == 0);
            cnt = (cnt + 99) % 100;
        end
        if (rst || clr) begin
            age = -1;
        end else if (exp_wrap) begin
            age = 0;
        end else if (age >= 0) begin
            age++;
            if (age == 4 * C) age = -1;
        end
        @(posedge clk);
        #1;
        nstep++;
        $display("step %0d rst=%0b inc=%0b dec=%0b clr=%0b blz=%0b -> %0d%0d wrap=%0b seg1=%07b seg2=%07b",
                 nstep, rst, inc, dec, clr, blz, o_tens, o_ones, o_wrap, seg1, seg2);
        chk("tens", 32'(o_tens), 32'(cnt / 10));
        chk("ones", 32'(o_ones), 32'(cnt % 10));
        chk("wrap", 32'(o_wrap), 32'(exp_wrap));
        chk("seg1", 32'(seg1), 32'(exp_seg1));
        chk("seg2", 32'(seg2), 32'(exp_seg2));
    endtask

    task automatic idle(input int n);
        rst = 0; inc = 0; dec = 0; clr = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse(input logic p_inc, input logic p_dec, input logic p_clr);
        inc = p_inc; dec = p_dec; clr = p_clr;
        step();
        inc = 0; dec = 0; clr = 0;
    endtask

    initial begin
        int darkcnt;
        // 1. reset
        rst = 1; blz = 0;
        step();
        step();
        chk("reset_seg1_dark", 32'(seg1), 32'h7F);
        chk("reset_seg2_dark", 32'(seg2), 32'h7F);
        rst = 0;
        step();
        chk("release_seg1_zero", 32'(seg1), 32'b0000001);
        chk("release_seg2_zero", 32'(seg2), 32'b0000001);

        // 2. count to 42, then leading-zero blanking at 07
        for (int i = 0; i < 42; i++) begin
            pulse(1, 0, 0);
            idle(1);
        end
        chk("count42_tens", 32'(o_tens), 32'd4);
        chk("count42_ones", 32'(o_ones), 32'd2);
        chk("count42_seg1", 32'(seg1), 32'b1001100);
        chk("count42_seg2", 32'(seg2), 32'b0010010);
        blz = 1;
        pulse(0, 0, 1);
        for (int i = 0; i < 7; i++) pulse(1, 0, 0);
        idle(1);
        chk("lz_seg1_blank", 32'(seg1), 32'h7F);
        chk("lz_seg2_seven", 32'(seg2), 32'b0001111);

        // 3. 07 -> 99, then wrap and watch the full flash
        for (int i = 0; i < 92; i++) pulse(1, 0, 0);
        pulse(1, 0, 0);
        chk("inc_wrap_pulse", 32'(o_wrap), 32'd1);
        darkcnt = 0;
        for (int i = 0; i < 4 * C + 1; i++) begin
            idle(1);
            if (seg2 == 7'h7F) darkcnt++;
        end
        chk("flash_dark_cycles", 32'(darkcnt), 32'(2 * C));

        // 4. decrement wrap, inc+dec hold, restart mid-ON1
        pulse(0, 1, 0);
        chk("dec_wrap_count", 32'(o_tens * 10 + o_ones), 32'd99);
        inc = 1; dec = 1;
        for (int i = 0; i < 5; i++) step();
        inc = 0; dec = 0;
        chk("incdec_hold", 32'(o_tens * 10 + o_ones), 32'd99);
        pulse(1, 0, 0);
        darkcnt = 0;
        for (int i = 0; i < C + 1; i++) begin
            idle(1);
            if (seg2 == 7'h7F) darkcnt++;
        end
        chk("restart_dark_cycles", 32'(darkcnt), 32'(C));
        idle(3 * C + 2);

        // 5. clear wins over inc during OFF1 and aborts the flash
        blz = 0;
        pulse(0, 1, 0);
        pulse(1, 0, 1);
        chk("clr_no_wrap", 32'(o_wrap), 32'd0);
        idle(1);
        chk("clr_seg2_zero", 32'(seg2), 32'b0000001);
        idle(2 * C);

        // 6. reset in the middle of OFF2
        for (int i = 0; i < 37; i++) pulse(1, 0, 0);
        for (int i = 0; i < 63; i++) pulse(1, 0, 0);
        idle(2 * C + 1);
        rst = 1;
        step();
        rst = 0;
        idle(4 * C + 4);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            int r;
            r   = int'($urandom_range(0, 199));
            rst = (r == 0);
            clr = (r >= 1 && r < 5);
            inc = ($urandom_range(0, 9) < 5);
            dec = ($urandom_range(0, 9) < 4);
            if ((i % 50) == 0) blz = $urandom_range(0, 1) == 1;
            step();
        end
        idle(4 * C + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
